// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect tone generator.
//   sfx_state_e : effect FSM state (IDLE, FLAP, HIT)
//   sample_t    : 24-bit signed two's-complement audio sample
//   FLAP_AMP    : fixed flap amplitude
//   HIT_AMP     : initial hit amplitude before decay
package sfx_pkg;

    localparam int unsigned SAMPLE_W = 24;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLAP = 2'd1,
        HIT  = 2'd2
    } sfx_state_e;

    localparam sample_t FLAP_AMP = 24'h200000;
    localparam sample_t HIT_AMP  = 24'h400000;

endpackage

// File: rtl/square_osc.sv
// Square-wave oscillator: half-period sample counter, phase toggle and sign
// application on a caller-supplied amplitude.
//   CLOCK_50  : clock
//   reset_n   : synchronous active-low reset
//   clear     : restart at count 0 with positive phase
//   advance   : one accepted sample
//   amp       : magnitude to output
//   sample_c  : +amp or -amp depending on phase (combinational)
module square_osc #(
    parameter int unsigned HALF = 24,
    parameter int unsigned W    = 24
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] amp,
    output logic [W-1:0] sample_c
);

    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] half_cnt;
    logic             phase_neg;

    // Half-period counter; phase flips after every HALF accepted samples.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n || clear) begin
            half_cnt  <= '0;
            phase_neg <= 1'b0;
        end else if (advance) begin
            if (half_cnt == CNT_LAST) begin
                half_cnt  <= '0;
                phase_neg <= ~phase_neg;
            end else begin
                half_cnt <= half_cnt + CNT_W'(1);
            end
        end
    end

    assign sample_c = phase_neg ? (~amp + W'(1)) : amp;

endmodule

// File: rtl/sfx_tone_gen.sv
// Flap / hit sound-effect generator feeding an audio codec write port.
//   CLOCK_50        : clock
//   reset_n         : synchronous active-low reset
//   flap_trig       : one-cycle request for the flap effect
//   hit_trig        : one-cycle request for the hit effect (wins over flap)
//   write_ready     : codec can take a sample this cycle
//   write           : sample offered (always equals write_ready)
//   writedata_left  : registered signed sample
//   writedata_right : same sample as left
//   busy            : an effect is playing
module sfx_tone_gen
    import sfx_pkg::*;
#(
    parameter int unsigned FLAP_HALF = 24,
    parameter int unsigned FLAP_LEN  = 4800,
    parameter int unsigned HIT_HALF  = 96,
    parameter int unsigned HIT_LEN   = 14400,
    parameter int unsigned HIT_DECAY = 3600
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        flap_trig,
    input  logic        hit_trig,
    input  logic        write_ready,
    output logic        write,
    output logic [23:0] writedata_left,
    output logic [23:0] writedata_right,
    output logic        busy
);

    localparam int unsigned LEN_MAX = (FLAP_LEN > HIT_LEN) ? FLAP_LEN : HIT_LEN;
    localparam int unsigned LEN_W   = $clog2(LEN_MAX) + 1;
    localparam int unsigned DEC_W   = $clog2(HIT_DECAY) + 1;

    localparam logic [LEN_W-1:0] FLAP_LAST  = LEN_W'(FLAP_LEN - 1);
    localparam logic [LEN_W-1:0] HIT_LAST   = LEN_W'(HIT_LEN - 1);
    localparam logic [DEC_W-1:0] DECAY_LAST = DEC_W'(HIT_DECAY - 1);

    sfx_state_e       state;
    logic [LEN_W-1:0] len_cnt;
    logic [DEC_W-1:0] decay_cnt;
    sample_t          hit_amp;
    sample_t          sample_q;
    sample_t          flap_sample;
    sample_t          hit_sample;

    logic start_flap;
    logic start_hit;
    logic adv_flap;
    logic adv_hit;

    // The codec is never starved: silence is a valid sample.
    assign write = write_ready;

    // Trigger decode; a trigger discards any sample accepted on the same cycle.
    always_comb begin
        start_flap = 1'b0;
        start_hit  = 1'b0;
        case (state)
            IDLE, FLAP: begin
                if (hit_trig)       start_hit  = 1'b1;
                else if (flap_trig) start_flap = 1'b1;
            end
            HIT:     start_hit = hit_trig;
            default: ;
        endcase
        adv_flap = (state == FLAP) && write_ready && !start_flap && !start_hit;
        adv_hit  = (state == HIT)  && write_ready && !start_hit;
    end

    square_osc #(.HALF(FLAP_HALF), .W(SAMPLE_W)) u_flap_osc (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .clear    (start_flap),
        .advance  (adv_flap),
        .amp      (FLAP_AMP),
        .sample_c (flap_sample)
    );

    square_osc #(.HALF(HIT_HALF), .W(SAMPLE_W)) u_hit_osc (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .clear    (start_hit),
        .advance  (adv_hit),
        .amp      (hit_amp),
        .sample_c (hit_sample)
    );

    // Effect FSM, length counter, hit decay and output register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state     <= IDLE;
            len_cnt   <= '0;
            decay_cnt <= '0;
            hit_amp   <= '0;
            sample_q  <= '0;
            busy      <= 1'b0;
        end else begin
            // Output reflects the current state/phase/amplitude one cycle later.
            case (state)
                FLAP:    sample_q <= flap_sample;
                HIT:     sample_q <= hit_sample;
                default: sample_q <= '0;
            endcase

            if (start_hit) begin
                state     <= HIT;
                len_cnt   <= '0;
                decay_cnt <= '0;
                hit_amp   <= HIT_AMP;
                busy      <= 1'b1;
            end else if (start_flap) begin
                state     <= FLAP;
                len_cnt   <= '0;
                decay_cnt <= '0;
                busy      <= 1'b1;
            end else if (adv_flap) begin
                if (len_cnt == FLAP_LAST) begin
                    state   <= IDLE;
                    len_cnt <= '0;
                    busy    <= 1'b0;
                end else begin
                    len_cnt <= len_cnt + LEN_W'(1);
                end
            end else if (adv_hit) begin
                if (len_cnt == HIT_LAST) begin
                    state     <= IDLE;
                    len_cnt   <= '0;
                    decay_cnt <= '0;
                    hit_amp   <= '0;
                    busy      <= 1'b0;
                end else begin
                    len_cnt <= len_cnt + LEN_W'(1);
                    if (decay_cnt == DECAY_LAST) begin
                        decay_cnt <= '0;
                        hit_amp   <= {hit_amp[SAMPLE_W-1], hit_amp[SAMPLE_W-1:1]};
                    end else begin
                        decay_cnt <= decay_cnt + DEC_W'(1);
                    end
                end
            end
        end
    end

    assign writedata_left  = sample_q;
    assign writedata_right = sample_q;

endmodule

// File: doc/sfx_tone_gen.md
SFX_TONE_GEN -- requirements
Module: sfx_tone_gen

Interface
REQ-001 Parameter FLAP_HALF, default 24, flap tone half-period in samples (1 kHz at 48 kHz).
REQ-002 Parameter FLAP_LEN, default 4800, flap duration in samples (100 ms).
REQ-003 Parameter HIT_HALF, default 96, hit tone half-period in samples (250 Hz).
REQ-004 Parameter HIT_LEN, default 14400, hit duration in samples (300 ms).
REQ-005 Parameter HIT_DECAY, default 3600, samples between hit amplitude halvings.
REQ-006 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  synchronous reset, active-low.
REQ-008 flap_trig  input  1  one-cycle request to play the flap effect.
REQ-009 hit_trig  input  1  one-cycle request to play the hit effect.
REQ-010 write_ready  input  1  audio codec can accept a sample this cycle.
REQ-011 write  output  1  sample offered to the codec.
REQ-012 writedata_left  output  24  signed two's-complement sample, left channel.
REQ-013 writedata_right  output  24  signed sample, right channel, always equal to left.
REQ-014 busy  output  1  high while an effect is playing.

Function
REQ-015 write SHALL equal write_ready combinationally: the block always supplies a sample, and silence is 0.
REQ-016 A sample is accepted on every cycle where write and write_ready are both high. Sample counters SHALL advance only on accepted cycles.
REQ-017 The FSM SHALL have three states: IDLE, FLAP and HIT. busy is high in FLAP and in HIT.
REQ-018 IDLE: hit_trig goes to HIT; otherwise flap_trig goes to FLAP. Counters clear on entry and phase starts positive.
REQ-019 FLAP: hit_trig preempts to HIT with fresh counters; flap_trig restarts FLAP with counters cleared.
REQ-020 HIT: flap_trig is ignored; hit_trig restarts HIT with counters and amplitude reset.
REQ-021 A trigger arriving on the same cycle as an accepted sample SHALL take priority. The accepted sample is discarded from the old effect's counting.
REQ-022 Phase SHALL toggle after every HALF accepted samples of the active effect.
REQ-023 Output is +amp while phase is positive and -amp (two's complement) while negative.
REQ-024 FLAP amplitude SHALL be fixed at 24'h200000.
REQ-025 HIT amplitude SHALL start at 24'h400000 and arithmetic-shift right by 1 after every HIT_DECAY accepted samples. It never goes below 0.
REQ-026 After LEN accepted samples the FSM SHALL return to IDLE. busy falls on that same clock edge.
REQ-027 writedata SHALL be registered and update the cycle after any state, phase or amplitude change.
REQ-028 writedata SHALL be 0 in IDLE.
REQ-029 When write_ready is low, all counters, phase and amplitude SHALL hold.
REQ-030 The length counter width SHALL be $clog2 of the largest LEN plus 1.
REQ-031 The counter SHALL compare against LEN-1 with no wrap-around before termination.

Reset
REQ-032 While reset_n is low at a clock edge: state goes to IDLE, all counters to 0, phase to positive, amplitude to 0, writedata to 0 and busy to 0.
REQ-033 While reset_n is low, write still equals write_ready.
REQ-034 Reset asserted mid-effect SHALL abort the effect within one cycle. Triggers present during reset are ignored.

Structure
REQ-035 A shared package sfx_pkg SHALL hold the state enum (IDLE, FLAP, HIT), the amplitude constants and the 24-bit sample typedef.
REQ-036 One sub-module square_osc SHALL hold the half-period counter, the phase toggle and the sign application. It has parameters for half-period and width.
REQ-037 The top module holds the FSM, the length counter and the decay logic.

Verification
REQ-038 Flap, write_ready held high: flap_trig pulse -> busy for exactly 4800 cycles.
- writedata is +24'h200000 for 24 samples, then 24'hE00000 for 24 samples, repeating.
- After the effect, writedata is 0.
REQ-039 Hit, write_ready high: hit_trig pulse -> amplitude is 0x400000 for samples 0-3599, 0x200000 for 3600-7199, 0x100000 for 7200-10799, and 0x080000 for 10800-14399.
- Then IDLE.
REQ-040 Preempt: flap_trig, then hit_trig at sample 100 -> HIT waveform starting positive at 0x400000 and lasting a full 14400 samples.
- flap_trig during HIT has no effect.
REQ-041 Throttled handshake: write_ready high 1 cycle in 1042 -> effect lasts 4800 accepted samples.
- Data is stable between accepts.
REQ-042 Reset mid-HIT: reset_n low for 1 cycle at sample 5000 -> next cycle busy=0, writedata=0, state IDLE.
REQ-043 Simultaneous flap_trig and hit_trig in IDLE -> HIT is entered.
